// File: rtl/uart_cmd_engine.sv
// Line-oriented UART command parser: "<cmd>[,<hex>...]" + CR/LF -> table match,
// hex argument decode, valid/ready dispatch, and an "OK xx" / "ER xx" reply.
module uart_cmd_engine #(
  parameter int MAX_CMD_LEN = 12,
  parameter int NUM_CMDS    = 4,
  parameter logic [NUM_CMDS*MAX_CMD_LEN*8-1:0] CMD_TABLE =
    {"pb_i_write  ", "pb_i_read   ", "pb_reset    ", "status      "},
  parameter int MAX_ARGS    = 4,
  parameter int ARG_WIDTH   = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             rx_fifo_empty,
  input  logic [7:0]                       rx_fifo_data_out,
  output logic                             rx_fifo_read_en,
  input  logic                             tx_fifo_full,
  output logic [7:0]                       tx_fifo_data_in,
  output logic                             tx_fifo_write_en,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic [$clog2(NUM_CMDS)-1:0]      cmd_id,
  output logic [$clog2(MAX_ARGS+1)-1:0]    cmd_arg_count,
  output logic [MAX_ARGS*ARG_WIDTH-1:0]    cmd_args,
  input  logic                             done_valid,
  input  logic [7:0]                       done_status,
  input  logic [7:0]                       done_data,
  output logic                             busy
);

  localparam int LEN_W = $clog2(MAX_CMD_LEN + 1);
  localparam int ID_W  = $clog2(NUM_CMDS);
  localparam int CNT_W = $clog2(MAX_ARGS + 1);
  localparam int DIGS  = ARG_WIDTH / 4;
  localparam int DIG_W = $clog2(DIGS + 1);

  typedef enum logic [2:0] {RX_CMD, RX_ARG, DISCARD, DISPATCH, WAIT_DONE, RESP} state_t;

  state_t                 state, state_nx;
  logic [7:0]             cmd_buf [MAX_CMD_LEN];
  logic [LEN_W-1:0]       cmd_len;
  logic [ARG_WIDTH-1:0]   args_q [MAX_ARGS];
  logic [CNT_W-1:0]       arg_idx;
  logic [DIG_W-1:0]       dig_cnt;
  logic                   resp_err;
  logic [7:0]             resp_val;
  logic [2:0]             tx_idx;
  logic                   err_set;
  logic [7:0]             err_nx;
  logic                   is_term, is_sep, is_hex;
  logic [3:0]             nib;
  logic [MAX_CMD_LEN*8-1:0] buf_word;
  logic                   match_any;
  logic [ID_W-1:0]        match_id;

  function automatic logic hex_digit(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
  endfunction

  function automatic logic [3:0] hex_nibble(input logic [7:0] b);
    logic [7:0] t;
    if (b <= "9")      t = b - 8'h30;
    else if (b <= "F") t = b - 8'h37;
    else               t = b - 8'h57;
    return t[3:0];
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign is_term = (rx_fifo_data_out == 8'h0D) || (rx_fifo_data_out == 8'h0A);
  assign is_sep  = (rx_fifo_data_out == ",");
  assign is_hex  = hex_digit(rx_fifo_data_out);
  assign nib     = hex_nibble(rx_fifo_data_out);

  // Buffer is kept space-filled, so it compares directly against padded entries.
  always_comb begin
    buf_word  = '0;
    match_any = 1'b0;
    match_id  = '0;
    for (int i = 0; i < MAX_CMD_LEN; i++)
      buf_word[(MAX_CMD_LEN-i)*8-1 -: 8] = cmd_buf[i];
    for (int e = NUM_CMDS - 1; e >= 0; e--)
      if (buf_word == CMD_TABLE[(NUM_CMDS-e)*MAX_CMD_LEN*8-1 -: MAX_CMD_LEN*8]) begin
        match_any = 1'b1;
        match_id  = ID_W'(e);
      end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RX_CMD;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    err_nx   = 8'h00;
    case (state)
      RX_CMD: if (rx_fifo_read_en) begin
        if (is_term || is_sep) begin
          if (is_term && cmd_len == '0) begin
            state_nx = RX_CMD;
          end else if (!match_any) begin
            err_set  = 1'b1;
            err_nx   = 8'h01;
            state_nx = is_sep ? DISCARD : RESP;
          end else begin
            state_nx = is_sep ? RX_ARG : DISPATCH;
          end
        end else if (cmd_len == LEN_W'(MAX_CMD_LEN)) begin
          err_set  = 1'b1;
          err_nx   = 8'h05;
          state_nx = DISCARD;
        end
      end
      RX_ARG: if (rx_fifo_read_en) begin
        if (is_hex) begin
          if (dig_cnt == DIG_W'(DIGS)) begin
            err_set  = 1'b1;
            err_nx   = 8'h04;
            state_nx = DISCARD;
          end
        end else if (is_sep || is_term) begin
          if (dig_cnt == '0) begin
            err_set = 1'b1;
            err_nx  = 8'h02;
          end else if (arg_idx == CNT_W'(MAX_ARGS)) begin
            err_set = 1'b1;
            err_nx  = 8'h03;
          end
          if (err_set)      state_nx = is_term ? RESP : DISCARD;
          else if (is_term) state_nx = DISPATCH;
        end else begin
          err_set  = 1'b1;
          err_nx   = 8'h02;
          state_nx = DISCARD;
        end
      end
      DISCARD:   if (rx_fifo_read_en && is_term) state_nx = RESP;
      DISPATCH:  if (cmd_ready) state_nx = WAIT_DONE;
      WAIT_DONE: if (done_valid) state_nx = RESP;
      RESP:      if (!tx_fifo_full && tx_idx == 3'd6) state_nx = RX_CMD;
      default:   state_nx = RX_CMD;
    endcase
  end

  // Pops are registered one cycle ahead; the self-clearing term forces the gap cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_fifo_read_en <= 1'b0;
    else          rx_fifo_read_en <= !rx_fifo_read_en && !rx_fifo_empty &&
                                     (state_nx inside {RX_CMD, RX_ARG, DISCARD});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < MAX_CMD_LEN; k++) cmd_buf[k] <= 8'h20;
      for (int k = 0; k < MAX_ARGS; k++)    args_q[k]  <= '0;
      cmd_len       <= '0;
      arg_idx       <= '0;
      dig_cnt       <= '0;
      cmd_id        <= '0;
      cmd_arg_count <= '0;
      resp_err      <= 1'b0;
      resp_val      <= 8'h00;
      tx_idx        <= 3'd0;
    end else begin
      if (err_set) begin
        resp_err <= 1'b1;
        resp_val <= err_nx;
      end
      case (state)
        RX_CMD: if (rx_fifo_read_en) begin
          if (!is_term && !is_sep) begin
            if (cmd_len != LEN_W'(MAX_CMD_LEN)) begin
              for (int k = 0; k < MAX_CMD_LEN; k++)
                if (cmd_len == LEN_W'(k)) cmd_buf[k] <= rx_fifo_data_out;
              cmd_len <= cmd_len + LEN_W'(1);
            end
          end else if (match_any) begin
            cmd_id        <= match_id;
            cmd_arg_count <= '0;
          end
        end
        RX_ARG: if (rx_fifo_read_en) begin
          if (is_hex && dig_cnt != DIG_W'(DIGS)) begin
            // Digits of an over-limit argument are counted but never stored.
            for (int k = 0; k < MAX_ARGS; k++)
              if (arg_idx == CNT_W'(k)) args_q[k] <= {args_q[k][ARG_WIDTH-5:0], nib};
            dig_cnt <= dig_cnt + DIG_W'(1);
          end else if (is_sep && state_nx == RX_ARG) begin
            arg_idx <= arg_idx + CNT_W'(1);
            dig_cnt <= '0;
          end else if (is_term && state_nx == DISPATCH) begin
            cmd_arg_count <= arg_idx + CNT_W'(1);
          end
        end
        WAIT_DONE: if (done_valid) begin
          resp_err <= (done_status != 8'h00);
          resp_val <= (done_status != 8'h00) ? done_status : done_data;
        end
        RESP: if (!tx_fifo_full) begin
          if (tx_idx == 3'd6) begin
            for (int k = 0; k < MAX_CMD_LEN; k++) cmd_buf[k] <= 8'h20;
            for (int k = 0; k < MAX_ARGS; k++)    args_q[k]  <= '0;
            cmd_len       <= '0;
            arg_idx       <= '0;
            dig_cnt       <= '0;
            cmd_id        <= '0;
            cmd_arg_count <= '0;
            resp_err      <= 1'b0;
            resp_val      <= 8'h00;
            tx_idx        <= 3'd0;
          end else begin
            tx_idx <= tx_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_valid        = (state == DISPATCH);
    busy             = !(state == RX_CMD && cmd_len == '0);
    tx_fifo_write_en = (state == RESP) && !tx_fifo_full;
    tx_fifo_data_in  = 8'h00;
    if (state == RESP) begin
      case (tx_idx)
        3'd0:    tx_fifo_data_in = resp_err ? "E" : "O";
        3'd1:    tx_fifo_data_in = resp_err ? "R" : "K";
        3'd2:    tx_fifo_data_in = " ";
        3'd3:    tx_fifo_data_in = hex_char(resp_val[7:4]);
        3'd4:    tx_fifo_data_in = hex_char(resp_val[3:0]);
        3'd5:    tx_fifo_data_in = 8'h0D;
        default: tx_fifo_data_in = 8'h0A;
      endcase
    end
  end

  always_comb begin
    cmd_args = '0;
    for (int k = 0; k < MAX_ARGS; k++)
      cmd_args[k*ARG_WIDTH +: ARG_WIDTH] = args_q[k];
  end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed bench for uart_cmd_engine: FIFO models, auto-completing downstream,
// a vector table of command lines, and hand sequences for handshake, TX back-pressure and reset.
module tb_uart_cmd_engine;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_fifo_empty = 1'b1;
  logic [7:0]  rx_fifo_data_out = 8'h00;
  logic        rx_fifo_read_en;
  logic        tx_fifo_full = 1'b0;
  logic [7:0]  tx_fifo_data_in;
  logic        tx_fifo_write_en;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [1:0]  cmd_id;
  logic [2:0]  cmd_arg_count;
  logic [63:0] cmd_args;
  logic        done_valid = 1'b0;
  logic [7:0]  done_status = 8'h00;
  logic [7:0]  done_data = 8'h00;
  logic        busy;

  uart_cmd_engine dut (
    .clock(clock), .reset_n(reset_n),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_data_out(rx_fifo_data_out),
    .rx_fifo_read_en(rx_fifo_read_en),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_data_in(tx_fifo_data_in),
    .tx_fifo_write_en(tx_fifo_write_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_arg_count(cmd_arg_count), .cmd_args(cmd_args),
    .done_valid(done_valid), .done_status(done_status), .done_data(done_data),
    .busy(busy)
  );

  initial forever #5 clock = ~clock;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic        pop_pend = 1'b0;
  logic        prev_pop = 1'b0;
  logic        done_pend = 1'b0;
  int          pop_err = 0;
  int          push_err = 0;
  int          hs_count = 0;
  logic [1:0]  hs_id = '0;
  logic [2:0]  hs_cnt = '0;
  logic [63:0] hs_args = '0;
  int          checks = 0;
  int          errors = 0;

  // FIFO and downstream models: observe just after each falling edge, act on the next rising edge.
  initial forever begin
    @(negedge clock);
    #1;
    done_valid = done_pend;
    done_pend  = 1'b0;
    if (pop_pend && rx_q.size() > 0) void'(rx_q.pop_front());
    pop_pend = 1'b0;
    rx_fifo_empty    = (rx_q.size() == 0);
    rx_fifo_data_out = rx_fifo_empty ? 8'h00 : rx_q[0];
    if (rx_fifo_read_en) begin
      if (rx_fifo_empty || prev_pop) pop_err++;
      pop_pend = 1'b1;
    end
    prev_pop = rx_fifo_read_en;
    if (tx_fifo_write_en) begin
      if (tx_fifo_full) push_err++;
      tx_q.push_back(tx_fifo_data_in);
    end
    if (cmd_valid && cmd_ready) begin
      hs_count++;
      hs_id     = cmd_id;
      hs_cnt    = cmd_arg_count;
      hs_args   = cmd_args;
      done_pend = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
  endtask

  function automatic logic [55:0] resp_word(input string s);
    return {s[0], s[1], s[2], s[3], s[4], 8'h0D, 8'h0A};
  endfunction

  function automatic logic [55:0] tx_word();
    logic [55:0] w = '0;
    for (int i = 0; i < 7; i++)
      if (i < tx_q.size()) w[(6-i)*8 +: 8] = tx_q[i];
    return w;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(tx_q.size() >= 7 && rx_q.size() == 0 && !busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({name, " finish"}, 64'(n < budget), 64'd1);
    repeat (4) @(negedge clock);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, " read_en"},  64'(rx_fifo_read_en), 64'd0);
    chk({name, " write_en"}, 64'(tx_fifo_write_en), 64'd0);
    chk({name, " tx_data"},  64'(tx_fifo_data_in), 64'd0);
    chk({name, " cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({name, " cmd_id"},   64'(cmd_id), 64'd0);
    chk({name, " arg_count"}, 64'(cmd_arg_count), 64'd0);
    chk({name, " cmd_args"}, cmd_args, 64'd0);
    chk({name, " busy"},     64'(busy), 64'd0);
  endtask

  typedef struct {
    string       line;
    bit          exp_cmd;
    int          exp_id;
    int          exp_cnt;
    logic [63:0] exp_args;
    logic [7:0]  st;
    logic [7:0]  dt;
    string       resp;
  } vec_t;

  // "\015" is CR, "\012" is LF.
  vec_t vecs[14];

  initial begin
    int hs0, n, sz;
    vecs[0]  = '{"pb_i_write,12,AB\015\012", 1, 0, 2, 64'h0000_0000_00AB_0012, 8'h00, 8'h5A, "OK 5A"};
    vecs[1]  = '{"pb_i_read,1,a2,FFFF,0\015", 1, 1, 4, 64'h0000_FFFF_00A2_0001, 8'h3C, 8'h11, "ER 3C"};
    vecs[2]  = '{"foo,1\015",                 0, 0, 0, 64'h0, 8'h00, 8'h00, "ER 01"};
    vecs[3]  = '{"pb_reset\015",              1, 2, 0, 64'h0, 8'h00, 8'hC3, "OK C3"};
    vecs[4]  = '{"pb_i_read,12345\015",       0, 0, 0, 64'h0, 8'h00, 8'h00, "ER 04"};
    vecs[5]  = '{"pb_i_read,1,,2\015",        0, 0, 0, 64'h0, 8'h00, 8'h00, "ER 02"};
    vecs[6]  = '{"pb_i_read,1,2,3,4,5\015",   0, 0, 0, 64'h0, 8'h00, 8'h00, "ER 03"};
    vecs[7]  = '{"pb_i_write_extra\015",      0, 0, 0, 64'h0, 8'h00, 8'h00, "ER 05"};
    vecs[8]  = '{"pb_i_read,1g\015",          0, 0, 0, 64'h0, 8'h00, 8'h00, "ER 02"};
    vecs[9]  = '{"pb_i_read,\015",            0, 0, 0, 64'h0, 8'h00, 8'h00, "ER 02"};
    vecs[10] = '{"\015\012status\015\012",    1, 3, 0, 64'h0, 8'h00, 8'h7E, "OK 7E"};
    vecs[11] = '{"pb_i_write,dEaD\015",       1, 0, 1, 64'h0000_0000_0000_DEAD, 8'h00, 8'h01, "OK 01"};
    vecs[12] = '{"pb_i_wri\015",              0, 0, 0, 64'h0, 8'h00, 8'h00, "ER 01"};
    vecs[13] = '{"pb_i_read,FFFF,0001,2,3\015", 1, 1, 4, 64'h0003_0002_0001_FFFF, 8'h00, 8'h10, "OK 10"};

    // Reset state, with a byte already waiting in the RX FIFO.
    push_line("\015");
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (6) @(negedge clock);

    cmd_ready = 1'b1;
    for (int v = 0; v < 14; v++) begin
      tx_q.delete();
      hs0 = hs_count;
      done_status = vecs[v].st;
      done_data   = vecs[v].dt;
      push_line(vecs[v].line);
      wait_idle($sformatf("v%0d", v), 400);
      chk($sformatf("v%0d tx_count", v), 64'(tx_q.size()), 64'd7);
      chk($sformatf("v%0d response", v), 64'(tx_word()), 64'(resp_word(vecs[v].resp)));
      chk($sformatf("v%0d handshakes", v), 64'(hs_count - hs0), 64'(vecs[v].exp_cmd));
      if (vecs[v].exp_cmd) begin
        chk($sformatf("v%0d cmd_id", v), 64'(hs_id), 64'(vecs[v].exp_id));
        chk($sformatf("v%0d arg_count", v), 64'(hs_cnt), 64'(vecs[v].exp_cnt));
        chk($sformatf("v%0d cmd_args", v), hs_args, vecs[v].exp_args);
      end
    end

    // Downstream holds off: command fields stay put until one handshake.
    cmd_ready = 1'b0;
    tx_q.delete();
    hs0 = hs_count;
    done_status = 8'h00;
    done_data   = 8'h21;
    push_line("status\012");
    n = 0;
    while (!cmd_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("hold cmd_valid", 64'(cmd_valid), 64'd1);
    sz = 0;
    repeat (10) begin
      @(negedge clock);
      if (!(cmd_valid && cmd_id == 2'd3 && cmd_arg_count == 3'd0 && cmd_args == 64'd0)) sz++;
    end
    chk("hold stable cycles", 64'(sz), 64'd0);
    chk("hold no handshake", 64'(hs_count - hs0), 64'd0);
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready = 1'b0;
    wait_idle("hold", 200);
    chk("hold handshakes", 64'(hs_count - hs0), 64'd1);
    chk("hold response", 64'(tx_word()), 64'(resp_word("OK 21")));
    cmd_ready = 1'b1;

    // TX back-pressure toggling during the reply.
    tx_q.delete();
    pop_err  = 0;
    push_err = 0;
    done_data = 8'h99;
    push_line("pb_reset\015");
    n = 0;
    while (!(tx_q.size() >= 7 && rx_q.size() == 0 && !busy) && n < 400) begin
      @(negedge clock);
      tx_fifo_full = ~tx_fifo_full;
      n++;
    end
    tx_fifo_full = 1'b0;
    chk("bp finish", 64'(n < 400), 64'd1);
    repeat (6) @(negedge clock);
    chk("bp tx_count", 64'(tx_q.size()), 64'd7);
    chk("bp response", 64'(tx_word()), 64'(resp_word("OK 99")));
    chk("bp push while full", 64'(push_err), 64'd0);
    chk("bp pop spacing", 64'(pop_err), 64'd0);

    // Reset in the middle of an argument.
    tx_q.delete();
    push_line("pb_i_write,12");
    repeat (60) @(negedge clock);
    chk("midarg busy", 64'(busy), 64'd1);
    chk("midarg args", cmd_args, 64'h12);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midarg reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    hs0 = hs_count;
    done_data = 8'h42;
    push_line("status\015");
    wait_idle("midarg after", 200);
    chk("midarg tx_count", 64'(tx_q.size()), 64'd7);
    chk("midarg response", 64'(tx_word()), 64'(resp_word("OK 42")));
    chk("midarg cmd_id", 64'(hs_id), 64'd3);
    chk("midarg handshakes", 64'(hs_count - hs0), 64'd1);

    // Reset in the middle of the reply.
    tx_q.delete();
    done_data = 8'h77;
    push_line("pb_reset\015");
    n = 0;
    while (tx_q.size() < 3 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("midresp reached", 64'(n < 200), 64'd1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midresp reset");
    sz = tx_q.size();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("midresp no resume", 64'(tx_q.size()), 64'(sz));
    tx_q.delete();
    done_data = 8'h0D;
    push_line("status\015");
    wait_idle("midresp after", 200);
    chk("midresp tx_count", 64'(tx_q.size()), 64'd7);
    chk("midresp response", 64'(tx_word()), 64'(resp_word("OK 0D")));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
